// File: rtl/branch_target_predictor_if.sv
// rtl/branch_target_predictor_if.sv - fetch lookup / resolved-branch update bundle
//
// Purpose: groups the lookup request, prediction response, branch update and
// flush signals of the branch target predictor.
// Ports (signals):
//   lookupValid, lookupPc                 - fetch lookup request
//   predValid, predTaken, predTarget      - registered prediction
//   updateValid, updatePc,
//   updateInstruction, updateTaken        - resolved-branch update
//   flush                                 - invalidate all entries
// Modports: master drives lookups/updates/flush, slave is the predictor.
interface branch_target_predictor_if;
  logic        lookupValid;
  logic [31:0] lookupPc;
  logic        predValid;
  logic        predTaken;
  logic [31:0] predTarget;
  logic        updateValid;
  logic [31:0] updatePc;
  logic [31:0] updateInstruction;
  logic        updateTaken;
  logic        flush;

  modport master (
    output lookupValid, lookupPc,
    output updateValid, updatePc, updateInstruction, updateTaken, flush,
    input  predValid, predTaken, predTarget
  );

  modport slave (
    input  lookupValid, lookupPc,
    input  updateValid, updatePc, updateInstruction, updateTaken, flush,
    output predValid, predTaken, predTarget
  );
endinterface

// File: rtl/branch_target_predictor.sv
// rtl/branch_target_predictor.sv - direct-mapped branch target buffer with 2-bit counters
//
// Purpose: predicts direction and next PC for a fetch PC with one cycle of
// latency, and learns from resolved conditional branches and JALs.
// Ports:
//   clk   - clock, all state changes on the rising edge
//   rst_n - asynchronous active-low reset
//   bus   - branch_target_predictor_if.slave (lookup, prediction, update, flush)
module branch_target_predictor #(
  parameter int ENTRIES = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  branch_target_predictor_if.slave  bus
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // Entry storage
  logic             valid_q  [ENTRIES];
  logic             valid_d  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [TAG_W-1:0] tag_d    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [31:0]      target_d [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];
  logic [1:0]       ctr_d    [ENTRIES];

  // Registered prediction
  logic        pred_valid_q,  pred_valid_d;
  logic        pred_taken_q,  pred_taken_d;
  logic [31:0] pred_target_q, pred_target_d;

  // Lookup path: reads the current (pre-update) state, so a same-cycle
  // update or flush is never visible to the lookup issued with it.
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic             lk_taken;
  logic [31:0]      lk_target;

  always_comb begin
    lk_idx    = bus.lookupPc[IDX_W+1:2];
    lk_tag    = bus.lookupPc[31:IDX_W+2];
    lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    lk_taken  = lk_hit && ctr_q[lk_idx][1];
    lk_target = lk_taken ? target_q[lk_idx] : bus.lookupPc + 32'd4;
  end

  always_comb begin
    pred_valid_d  = bus.lookupValid;
    pred_taken_d  = pred_taken_q;
    pred_target_d = pred_target_q;
    if (bus.lookupValid) begin
      pred_taken_d  = lk_taken;
      pred_target_d = lk_target;
    end
  end

  // Update path: decode the resolved instruction's immediate and target.
  logic [31:0]      instr;
  logic             is_branch;
  logic             is_jal;
  logic [31:0]      imm_b;
  logic [31:0]      imm_j;
  logic [31:0]      up_target;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;

  always_comb begin
    instr     = bus.updateInstruction;
    is_branch = (instr[6:0] == OPC_BRANCH);
    is_jal    = (instr[6:0] == OPC_JAL);
    imm_b     = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    imm_j     = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    up_target = bus.updatePc + (is_jal ? imm_j : imm_b);
    up_idx    = bus.updatePc[IDX_W+1:2];
    up_tag    = bus.updatePc[31:IDX_W+2];
    up_hit    = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  end

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (bus.flush) begin
      // Flush wins over any same-cycle update; counters are left alone since
      // every allocation rewrites them.
      for (int i = 0; i < ENTRIES; i++) begin
        valid_d[i] = 1'b0;
      end
    end else if (bus.updateValid) begin
      if (is_jal) begin
        valid_d[up_idx]  = 1'b1;
        tag_d[up_idx]    = up_tag;
        target_d[up_idx] = up_target;
        ctr_d[up_idx]    = 2'b11;
      end else if (is_branch) begin
        if (up_hit) begin
          target_d[up_idx] = up_target;
          if (bus.updateTaken) begin
            ctr_d[up_idx] = (ctr_q[up_idx] == 2'b11) ? 2'b11 : ctr_q[up_idx] + 2'b01;
          end else begin
            ctr_d[up_idx] = (ctr_q[up_idx] == 2'b00) ? 2'b00 : ctr_q[up_idx] - 2'b01;
          end
        end else if (bus.updateTaken) begin
          valid_d[up_idx]  = 1'b1;
          tag_d[up_idx]    = up_tag;
          target_d[up_idx] = up_target;
          ctr_d[up_idx]    = 2'b10;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
      pred_valid_q  <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
    end else begin
      valid_q       <= valid_d;
      tag_q         <= tag_d;
      target_q      <= target_d;
      ctr_q         <= ctr_d;
      pred_valid_q  <= pred_valid_d;
      pred_taken_q  <= pred_taken_d;
      pred_target_q <= pred_target_d;
    end
  end

  assign bus.predValid  = pred_valid_q;
  assign bus.predTaken  = pred_taken_q;
  assign bus.predTarget = pred_target_q;

endmodule
